// File: rtl/cmsdk_apb4_eg_pkg.sv
// Shared types and constants for the APB4 example requester.
package cmsdk_apb4_eg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned     WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  // Saturating increment for the wait-state counter.
  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmsdk_apb4_eg_master_if.sv
// Command/response handshake plus APB4 bus signals of the example requester.
interface cmsdk_apb4_eg_master_if #(
  parameter int ADDRWIDTH = 12
);
  // Handshakes: a beat transfers on the rising PCLK edge where valid & ready;
  // valid never waits on ready, and an offered payload stays put until taken.
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic                 cmd_write;
  logic [31:0]          cmd_wdata;
  logic [3:0]           cmd_strb;
  logic [2:0]           cmd_prot;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_slverr;
  logic [7:0]           rsp_waits;

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_waits,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_waits,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/cmsdk_apb4_eg_master.sv
// APB4 requester: one command in, one APB4 transfer out, one response back.
module cmsdk_apb4_eg_master
  import cmsdk_apb4_eg_pkg::*;
#(
  parameter int ADDRWIDTH = 12
) (
  input  logic   PCLK,
  input  logic   PRESETn,
  cmsdk_apb4_eg_master_if.master bus,
  output state_t dbg_state
);

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           strb_q, strb_d;
  logic [2:0]           prot_q, prot_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 slverr_q, slverr_d;
  logic [WAIT_W-1:0]    waits_q, waits_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      waits_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prot_q   <= prot_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      waits_q  <= waits_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prot_d   = prot_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    waits_d  = waits_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          write_d = bus.cmd_write;
          wdata_d = bus.cmd_wdata;
          // APB4 reads must present all-zero strobes.
          strb_d  = bus.cmd_write ? bus.cmd_strb : 4'b0000;
          prot_d  = bus.cmd_prot;
          waits_d = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          slverr_d = bus.PSLVERR;
          rdata_d  = write_q ? 32'h0 : bus.PRDATA;
          state_d  = ST_RESP;
        end else begin
          waits_d = wait_inc(waits_q);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus control decodes straight from the state so reset drops PSEL at once.
  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.PSEL       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.PENABLE    = (state_q == ST_ACCESS);
  assign bus.PADDR      = addr_q;
  assign bus.PWRITE     = write_q;
  assign bus.PWDATA     = wdata_q;
  assign bus.PSTRB      = strb_q;
  assign bus.PPROT      = prot_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_slverr = slverr_q;
  assign bus.rsp_waits  = waits_q;
  assign dbg_state      = state_q;

endmodule
